// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding the 7-segment encoders.
// Optional leading-zero blanking is enabled by defining BIN_TO_BCD_LZ_BLANK_EN.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dig3,
    output logic [3:0]       dig2,
    output logic [3:0]       dig1,
    output logic [3:0]       dig0
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 16;
    localparam int unsigned CAT_W = ACC_W + WIDTH;
    localparam logic [3:0]  CODE_E     = 4'd10;
    localparam logic [3:0]  CODE_R     = 4'd11;
    localparam logic [3:0]  CODE_BLANK = 4'd13;
    localparam logic [ACC_W-1:0] DIGS_BLANK = {4{CODE_BLANK}};
    localparam logic [ACC_W-1:0] DIGS_ERR   = {CODE_BLANK, CODE_E, CODE_R, CODE_R};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sr,    w_sr_nxt;
    logic [ACC_W-1:0] r_acc,   w_acc_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_ovf,   w_ovf_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;
    logic [ACC_W-1:0] r_dig,   w_dig_nxt;

    logic [ACC_W-1:0] w_acc_adj;
    logic [CAT_W-1:0] w_cat;
    logic [ACC_W-1:0] w_fmt;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < 4; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_cat = {w_acc_adj, r_sr} << 1;

    // Display formatting: "Err" on overflow, otherwise the BCD digits.
    always_comb begin
        w_fmt = r_acc;
`ifdef BIN_TO_BCD_LZ_BLANK_EN
        if (r_acc[15:12] == 4'd0) begin
            w_fmt[15:12] = CODE_BLANK;
            if (r_acc[11:8] == 4'd0) begin
                w_fmt[11:8] = CODE_BLANK;
                if (r_acc[7:4] == 4'd0) begin
                    w_fmt[7:4] = CODE_BLANK;
                end
            end
        end
`endif
        if (r_ovf) begin
            w_fmt = DIGS_ERR;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_dig_nxt   = r_dig;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sr_nxt    = bin;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = CNT_W'(WIDTH);
                    w_ovf_nxt   = (32'(bin) > 32'd9999);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_acc_nxt = w_cat[CAT_W-1:WIDTH];
                w_sr_nxt  = w_cat[WIDTH-1:0];
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = FORMAT;
                end
            end
            FORMAT: begin
                w_dig_nxt   = w_fmt;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dig   <= DIGS_BLANK;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dig   <= w_dig_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dig3 = r_dig[15:12];
    assign dig2 = r_dig[11:8];
    assign dig1 = r_dig[7:4];
    assign dig0 = r_dig[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq; expected digits queued at start, compared at done.
// Honours BIN_TO_BCD_LZ_BLANK_EN in its reference model.
module tb_bin_to_bcd_seq;

    localparam int unsigned WIDTH = 14;
    localparam int          LAT   = WIDTH + 1;
    localparam logic [15:0] ALL_BLANK = 16'hDDDD;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [3:0]       dig3, dig2, dig1, dig0;
    logic [15:0]      digs;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp;

    always #5 clk = ~clk;

    assign digs = {dig3, dig2, dig1, dig0};

    bin_to_bcd_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .dig3  (dig3),
        .dig2  (dig2),
        .dig1  (dig1),
        .dig0  (dig0)
    );

    function automatic logic [15:0] model(input int v);
        logic [3:0] d3, d2, d1, d0;
        if (v > 9999) return 16'hDABB;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
`ifdef BIN_TO_BCD_LZ_BLANK_EN
        if (d3 == 4'd0) begin
            d3 = 4'd13;
            if (d2 == 4'd0) begin
                d2 = 4'd13;
                if (d1 == 4'd0) d1 = 4'd13;
            end
        end
`endif
        return {d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance up to max edges; n = edge count at which done was seen, -1 on timeout.
    task automatic wait_done(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        bin   = WIDTH'(1234);
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (digs !== ALL_BLANK) begin n_fail++; $display("FAIL reset_digits got %h want %h", digs, ALL_BLANK); end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
        last_exp = ALL_BLANK;
    endtask

    task automatic run_conversion(input int v);
        int          n;
        logic [15:0] e;
        bin   = WIDTH'(v);
        start = 1'b1;
        exp_q.push_back(model(v));
        tick();
        start = 1'b0;
        bin   = ~bin;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL conv%0d_busy got %b want 1", v, busy); end
        repeat (5) tick();
        n_checks++;
        if (digs !== last_exp) begin n_fail++; $display("FAIL conv%0d_hold got %h want %h", v, digs, last_exp); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL conv%0d_early_done got %b want 0", v, done); end
        wait_done(LAT + 10, n);
        n_checks++;
        if (n !== LAT - 5) begin n_fail++; $display("FAIL conv%0d_latency got %0d want %0d", v, n + 5, LAT); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (digs !== e) begin n_fail++; $display("FAIL conv%0d_digits got %h want %h", v, digs, e); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL conv%0d_busy_clear got %b want 0", v, busy); end
        last_exp = e;
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL conv%0d_done_pulse got %b want 0", v, done); end
    endtask

    task automatic test_normal();
        run_conversion(1234);
        run_conversion(4321);
    endtask

    task automatic test_blanking();
        run_conversion(7);
        run_conversion(0);
        run_conversion(9999);
        run_conversion(305);
    endtask

    task automatic test_overflow();
        run_conversion(10000);
        run_conversion(16383);
    endtask

    task automatic test_ignore_start();
        int          n;
        int          extra;
        logic [15:0] e;
        bin   = WIDTH'(1234);
        start = 1'b1;
        exp_q.push_back(model(1234));
        tick();
        start = 1'b0;
        repeat (4) tick();
        bin   = WIDTH'(5555);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(30, n);
        n_checks++;
        if (n !== LAT - 5) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", n + 5, LAT); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (digs !== e) begin n_fail++; $display("FAIL ignore_digits got %h want %h", digs, e); end
        last_exp = e;
        extra = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL ignore_no_requeue done pulses got %0d want 0", extra); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int          vals[3];
        int          n;
        logic [15:0] e;
        vals  = '{4321, 10000, 7};
        bin   = WIDTH'(vals[0]);
        start = 1'b1;
        exp_q.push_back(model(vals[0]));
        for (int k = 0; k < 3; k++) begin
            wait_done(40, n);
            n_checks++;
            if (n !== LAT + 1) begin n_fail++; $display("FAIL b2b%0d_spacing got %0d want %0d", k, n, LAT + 1); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            n_checks++;
            if (digs !== e) begin n_fail++; $display("FAIL b2b%0d_digits got %h want %h", k, digs, e); end
            last_exp = e;
            if (k < 2) begin
                bin = WIDTH'(vals[k+1]);
                exp_q.push_back(model(vals[k+1]));
            end else begin
                start = 1'b0;
            end
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop busy got %b want 0", busy); end
    endtask

    task automatic test_abort();
        int extra;
        bin   = WIDTH'(999);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++;
        if (digs !== ALL_BLANK) begin n_fail++; $display("FAIL abort_digits got %h want %h", digs, ALL_BLANK); end
        rst_n    = 1'b1;
        last_exp = ALL_BLANK;
        extra    = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL abort_no_done pulses got %0d want 0", extra); end
        run_conversion(42);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        last_exp = ALL_BLANK;
        test_reset();
        test_normal();
        test_blanking();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
